hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_ctrl_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 + matrix-MAC pipeline: shadows the
// EX/MEM/WB register fields and derives forwarding selects, stalls and flushes.
module hazard_ctrl_unit #(
  parameter int MAC_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_d,
  input  logic       reg_write_d,
  input  logic       load_d,
  input  logic       mac_d,
  input  logic       pc_src_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       mac_busy
);

  localparam int CNT_W = $clog2(MAC_LATENCY) + 1;
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(MAC_LATENCY - 1);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MAC_IDLE = 1'b0,
    MAC_BUSY = 1'b1
  } mac_state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       load;
    logic       mac;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
  } wr_stage_t;

  ex_stage_t        e_q, e_d;
  wr_stage_t        m_q, m_d;
  wr_stage_t        w_q;
  mac_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mac_stall;
  logic lwstall;
  logic flush_e_raw;

  // MEM has the younger result, so it is checked before WB; x0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input wr_stage_t m,
                                         input wr_stage_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (m.reg_write && (m.rd != 5'd0) && (m.rd == src)) begin
      sel = FWD_MEM;
    end else if (w.reg_write && (w.rd != 5'd0) && (w.rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    mac_stall   = e_q.mac && (cnt_q != MAC_LAST);
    lwstall     = e_q.load && e_q.reg_write && (e_q.rd != 5'd0) &&
                  ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    flush_e_raw = (lwstall || pc_src_e) && !mac_stall;
  end

  assign forward_a_e = fwd_sel(e_q.rs1, m_q, w_q);
  assign forward_b_e = fwd_sel(e_q.rs2, m_q, w_q);

  // Reset masks every control output at once, which also aborts a MAC stall.
  assign stall_f  = !rst && (lwstall || mac_stall);
  assign stall_d  = stall_f;
  assign stall_e  = !rst && mac_stall;
  assign flush_m  = stall_e;
  assign mac_busy = stall_e;
  assign flush_d  = !rst && pc_src_e && !mac_stall;
  assign flush_e  = !rst && flush_e_raw;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    e_d = e_q;
    if (!mac_stall) begin
      if (flush_e_raw) begin
        e_d = '0;
      end else begin
        e_d = ex_stage_t'{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                          reg_write: reg_write_d, load: load_d, mac: mac_d};
      end
    end
    // A held MAC sends bubbles into MEM until it finally leaves EX.
    m_d = wr_stage_t'{rd: e_q.rd, reg_write: e_q.reg_write && !mac_stall};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MAC_IDLE: begin
        if (mac_stall) begin
          state_d = MAC_BUSY;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      MAC_BUSY: begin
        if (mac_stall) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = MAC_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = MAC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      state_q <= MAC_IDLE;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= m_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios with literal
// expectations, then random traffic against a pipeline-level reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       reg_write_d = 1'b0, load_d = 1'b0, mac_d = 1'b0, pc_src_e = 1'b0;

  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic       sf [2], sd [2], se [2], fd [2], fe [2], fm [2], mb [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MAC_LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .load_d(load_d), .mac_d(mac_d), .pc_src_e(pc_src_e),
    .forward_a_e(fa[0]), .forward_b_e(fb[0]), .stall_f(sf[0]), .stall_d(sd[0]),
    .stall_e(se[0]), .flush_d(fd[0]), .flush_e(fe[0]), .flush_m(fm[0]), .mac_busy(mb[0])
  );

  hazard_ctrl_unit #(.MAC_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .load_d(load_d), .mac_d(mac_d), .pc_src_e(pc_src_e),
    .forward_a_e(fa[1]), .forward_b_e(fb[1]), .stall_f(sf[1]), .stall_d(sd[1]),
    .stall_e(se[1]), .flush_d(fd[1]), .flush_e(fe[1]), .flush_m(fm[1]), .mac_busy(mb[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instruction records per stage ----------
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, mac;
  } ins_t;

  ins_t       m_ex  [2];
  int         m_age [2];      // cycles the EX instruction has already spent in EX
  logic [4:0] m_mrd [2], m_wrd [2];
  logic       m_mrw [2], m_wrw [2];
  bit         seen_rst = 1'b0;

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic bit mac_hold(input int k);
    return m_ex[k].mac && (m_age[k] < lat(k) - 1);
  endfunction

  function automatic bit load_use(input int k);
    return m_ex[k].ld && m_ex[k].rw && (m_ex[k].rd != 0) &&
           ((m_ex[k].rd == rs1_d) || (m_ex[k].rd == rs2_d));
  endfunction

  function automatic logic [1:0] fwd(input int k, input logic [4:0] src);
    if (m_mrw[k] && m_mrd[k] != 0 && m_mrd[k] == src) return 2'b10;
    if (m_wrw[k] && m_wrd[k] != 0 && m_wrd[k] == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] expect_out(input int k);
    bit ms, lw, br;
    ms = !rst && mac_hold(k);
    lw = !rst && load_use(k);
    br = !rst && pc_src_e;
    return {fwd(k, m_ex[k].rs1), fwd(k, m_ex[k].rs2), lw | ms, lw | ms, ms,
            br & !ms, (lw | br) & !ms, ms, ms};
  endfunction

  function automatic logic [12:0] dut_out(input int k);
    return {fa[k], fb[k], sf[k], sd[k], se[k], fd[k], fe[k], fm[k], mb[k]};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ex[k] = '0; m_age[k] = 0;
        m_mrd[k] = '0; m_mrw[k] = 1'b0; m_wrd[k] = '0; m_wrw[k] = 1'b0;
        seen_rst = 1'b1;
      end else begin
        bit ms, ex_flush;
        ms       = mac_hold(k);
        ex_flush = (load_use(k) || pc_src_e) && !ms;
        m_wrd[k] = m_mrd[k];
        m_wrw[k] = m_mrw[k];
        m_mrd[k] = m_ex[k].rd;
        m_mrw[k] = m_ex[k].rw && !ms;
        if (ms) begin
          m_age[k]++;
        end else begin
          m_age[k] = 0;
          m_ex[k]  = ex_flush ? '0 : ins_t'{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                                            rw: reg_write_d, ld: load_d, mac: mac_d};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d_outputs", k), 32'(dut_out(k)), 32'(expect_out(k)));
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic w, input logic l, input logic m, input logic p,
                      input logic r = 1'b0);
    @(posedge clk);
    #1;
    rs1_d = a; rs2_d = b; rd_d = d;
    reg_write_d = w; load_d = l; mac_d = m; pc_src_e = p; rst = r;
    #3;
  endtask

  task automatic nop(input logic r = 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    nop();
    check("rst_fwd_a", 32'(fa[0]), 32'd0);
    check("rst_fwd_b", 32'(fb[0]), 32'd0);
    check("rst_stalls", 32'({sf[0], se[0], fd[0], fe[0]}), 32'd0);

    // ALU RAW: MEM forward, WB forward two behind, x0 never forwarded
    step(5'd1, 5'd2, 5'd5, 1, 0, 0, 0);
    step(5'd5, 5'd1, 5'd6, 1, 0, 0, 0);
    step(5'd3, 5'd5, 5'd10, 1, 0, 0, 0);
    check("raw_mem_fwd_a", 32'(fa[0]), 32'd2);
    check("raw_mem_fwd_b", 32'(fb[0]), 32'd0);
    nop();
    check("raw_wb_fwd_b", 32'(fb[0]), 32'd1);
    step(5'd1, 5'd2, 5'd0, 1, 0, 0, 0);
    step(5'd0, 5'd0, 5'd11, 1, 0, 0, 0);
    nop();
    check("x0_no_fwd", 32'({fa[0], fb[0]}), 32'd0);

    // both MEM and WB write x7: MEM wins
    step(5'd1, 5'd1, 5'd7, 1, 0, 0, 0);
    step(5'd2, 5'd2, 5'd7, 1, 0, 0, 0);
    step(5'd1, 5'd7, 5'd12, 1, 0, 0, 0);
    nop();
    check("memwb_prio_b", 32'(fb[0]), 32'd2);
    check("memwb_prio_a", 32'(fa[0]), 32'd0);

    // load-use: one stall cycle, then WB forwarding
    step(5'd2, 5'd0, 5'd3, 1, 1, 0, 0);
    step(5'd3, 5'd3, 5'd4, 1, 0, 0, 0);
    check("lu_stall_fd_fe", 32'({sf[0], sd[0], fe[0]}), 32'b111);
    check("lu_no_se_fd", 32'({se[0], fd[0]}), 32'd0);
    step(5'd3, 5'd3, 5'd4, 1, 0, 0, 0);
    check("lu_one_cycle", 32'(sf[0]), 32'd0);
    nop();
    check("lu_wb_fwd", 32'({fa[0], fb[0]}), 32'b0101);
    step(5'd2, 5'd0, 5'd0, 1, 1, 0, 0);
    step(5'd0, 5'd0, 5'd4, 1, 0, 0, 0);
    check("lu_x0_nostall", 32'({sf[0], fe[0]}), 32'd0);

    // taken branch
    nop();
    step(5'd1, 5'd2, 5'd5, 1, 0, 0, 1);
    check("br_flush", 32'({fd[0], fe[0]}), 32'b11);
    check("br_no_stall", 32'({sf[0], se[0]}), 32'd0);
    nop();
    check("br_one_cycle", 32'({fd[0], fe[0]}), 32'd0);

    // MAC: 3 stall cycles at latency 4, none at latency 1
    step(5'd1, 5'd2, 5'd13, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(5'd13, 5'd1, 5'd14, 1, 0, 0, 0);
      check($sformatf("mac_stall_%0d", i),
            32'({sf[0], sd[0], se[0], fm[0], mb[0], fe[0]}), 32'b111110);
      if (i == 0) check("mac_lat1_nostall", 32'({sf[1], se[1]}), 32'd0);
    end
    step(5'd13, 5'd1, 5'd14, 1, 0, 0, 0);
    check("mac_release", 32'({sf[0], se[0]}), 32'd0);
    nop();
    check("mac_fwd_mem", 32'(fa[0]), 32'd2);

    // reset in the second MAC stall cycle
    step(5'd1, 5'd2, 5'd13, 1, 0, 1, 0);
    step(5'd13, 5'd1, 5'd14, 1, 0, 0, 0);
    check("mac_pre_rst", 32'(se[0]), 32'd1);
    step(5'd13, 5'd1, 5'd14, 1, 0, 0, 0, 1'b1);
    check("rst_abort", 32'({sf[0], se[0], mb[0]}), 32'd0);
    nop();
    check("post_rst_all0", 32'(dut_out(0)), 32'd0);
    step(5'd1, 5'd2, 5'd13, 1, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(5'd13, 5'd1, 5'd14, 1, 0, 0, 0);
      n += int'(se[0]);
    end
    check("mac_full_after_rst", 32'(n), 32'd3);

    // random traffic, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic l, m, p;
      r = int'($urandom_range(0, 9));
      l = (r < 2);
      m = (r == 2 || r == 3);
      p = (!m_ex[0].ld && !m_ex[1].ld) ? ($urandom_range(0, 5) == 0) : 1'b0;
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), l, m, p, 1'($urandom_range(0, 63) == 0));
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
